// File: rtl/iob_reset_seq.sv
// Reset synchroniser and sequencer: synchronises arst_n_i deassertion, stretches it,
// then releases N_OUT active-high reset domains in ascending index order.
module iob_reset_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned N_OUT          = 3,
  parameter int unsigned STRETCH_CYCLES = 4,
  parameter int unsigned STEP_CYCLES    = 2
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             sw_rst_i,
  output logic [N_OUT-1:0] arst_o,
  output logic             done_o
);

  localparam int unsigned STRETCH_W = $clog2(STRETCH_CYCLES + 1);
  localparam int unsigned STEP_W    = $clog2(STEP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_STRETCH,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;
  logic [STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
  logic [STEP_W-1:0]      step_cnt_q, step_cnt_d;
  logic [N_OUT-1:0]       arst_q, arst_d, arst_shift;
  logic                   done_q, done_d;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

  // Domains release lowest index first, so shifting a zero in from the LSB
  // clears exactly the next output; an all-zero result means the last one went.
  assign arst_shift = arst_q << 1;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q       <= ST_RESET;
      stretch_cnt_q <= '0;
      step_cnt_q    <= '0;
      arst_q        <= '1;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stretch_cnt_q <= stretch_cnt_d;
      step_cnt_q    <= step_cnt_d;
      arst_q        <= arst_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stretch_cnt_d = stretch_cnt_q;
    step_cnt_d    = step_cnt_q;
    arst_d        = arst_q;
    done_d        = done_q;

    case (state_q)
      ST_RESET: begin
        if (sync_ok) begin
          state_d       = ST_STRETCH;
          stretch_cnt_d = '0;
        end
      end
      ST_STRETCH: begin
        if (stretch_cnt_q == STRETCH_W'(STRETCH_CYCLES - 1)) begin
          arst_d        = arst_shift;
          stretch_cnt_d = '0;
          step_cnt_d    = '0;
          if (arst_shift == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          stretch_cnt_d = stretch_cnt_q + STRETCH_W'(1);
        end
      end
      ST_RELEASE: begin
        if (step_cnt_q == STEP_W'(STEP_CYCLES - 1)) begin
          arst_d     = arst_shift;
          step_cnt_d = '0;
          if (arst_shift == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_RESET;
    endcase

    // Software reset overrides counter progress everywhere except before sync.
    if (sw_rst_i && (state_q != ST_RESET)) begin
      state_d       = ST_STRETCH;
      stretch_cnt_d = '0;
      step_cnt_d    = '0;
      arst_d        = '1;
      done_d        = 1'b0;
    end
  end

  assign arst_o = arst_q;
  assign done_o = done_q;

endmodule

// File: doc/iob_reset_seq.md
Name: iob_reset_seq

Overview:
Parametrised reset synchroniser and sequencer that succeeds the 2-stage fixed synchroniser.
- Takes one asynchronous active-low reset, synchronises its deassertion through a configurable-depth chain, and stretches it to a minimum width.
- Releases N_OUT active-high reset domains one after another, a fixed number of cycles apart.
- Accepts a synchronous software reset request that re-runs the sequence.
- Sits at SoC top and drives the per-subsystem resets (CPU, peripherals, Ethernet core, ...).

Parameters:
- SYNC_STAGES, 2: synchroniser flops on the deassertion path; legal range ≥2.
- N_OUT, 3: number of reset outputs, released in index order; legal range ≥1.
- STRETCH_CYCLES, 4: minimum cycles every output stays asserted after the synchronised release; legal range ≥1.
- STEP_CYCLES, 2: cycles between successive output releases; legal range ≥1.

Ports:
- clk_i  input  1  system clock
- arst_n_i  input  1  asynchronous reset, active-low
- sw_rst_i  input  1  synchronous software reset request, active-high, level-sampled
- arst_o  output  N_OUT  per-domain resets, active-high, asserted asynchronously, released synchronously
- done_o  output  1  high when all outputs are released

Behaviour:
- One clock; reset is asynchronous and active-low on arst_n_i. Every flop resets asynchronously on arst_n_i low.
- Reset values:
  - arst_o = all ones.
  - done_o = 0.
  - Synchroniser chain = 0.
  - FSM = RESET.
  - Counters = 0.
- All outputs are driven directly from flops, with no combinational path to the outputs. arst_n_i low asserts every output immediately, with no clock needed.
- Synchroniser:
  - The chain shifts in 1 each edge while arst_n_i is high.
  - sync_ok = the last stage.
  - It is high after SYNC_STAGES edges, counting the first edge at which arst_n_i is sampled high as edge 1.
- FSM states: RESET, STRETCH, RELEASE, DONE.
  - RESET: go to STRETCH on the first edge that samples sync_ok = 1; clear the stretch counter.
  - STRETCH:
    - On each edge with sw_rst_i = 0, the counter increments.
    - On the edge where the counter reaches STRETCH_CYCLES, clear arst_o[0], clear the step counter, and go to RELEASE.
    - If N_OUT = 1, go to DONE instead and set done_o on the same edge.
  - RELEASE:
    - The step counter increments each edge.
    - When it reaches STEP_CYCLES, clear the next output arst_o[i] and reset the step counter.
    - On the edge that clears arst_o[N_OUT-1], set done_o and go to DONE.
  - DONE: hold. Outputs = all zeros, done_o = 1.
- Release order is strictly ascending index. arst_o[i] never clears before arst_o[i-1].
- Timing with defaults, power-on (edge 1 = first edge with arst_n_i high):
  - sync_ok at edge 2; STRETCH entered at edge 3.
  - arst_o[0] clears at edge 7, arst_o[1] at edge 9, arst_o[2] and done_o at edge 11.
- General timing: arst_o[0] clears at edge SYNC_STAGES+1+STRETCH_CYCLES; arst_o[i] clears i*STEP_CYCLES later.
- sw_rst_i:
  - In STRETCH, RELEASE or DONE, an edge sampling sw_rst_i = 1 sets arst_o to all ones and done_o = 0, clears both counters, and goes to STRETCH.
  - While sw_rst_i stays high, the FSM stays in STRETCH with the counter held at 0.
  - arst_o[0] clears STRETCH_CYCLES edges after the last edge that sampled sw_rst_i high.
  - sw_rst_i is ignored in RESET.
- Reset mid-operation: arst_n_i low at any time, in any state and during any sw_rst_i, returns everything to reset values asynchronously. A glitch of any width asserts all outputs, and the full sequence then re-runs.
- Simultaneous events: arst_n_i low has priority over sw_rst_i, and sw_rst_i has priority over counter progress. Counters are sized $clog2(max+1) and never wrap, because they always clear on a match.

Test Plan:
- Power-on, defaults: release arst_n_i -> arst_o 111 until edge 6, 110 at edge 7, 100 at edge 9, 000 with done_o=1 at edge 11.
- arst_n_i pulsed low for 1 ns mid-clock while in DONE -> arst_o = 111 and done_o = 0 immediately (asynchronously); the sequence then repeats the edge 7/9/11 timing.
- sw_rst_i high for 1 cycle at edge E while in DONE -> arst_o = 111 after E; 110 at E+4, 100 at E+6, 000 and done_o at E+8.
- sw_rst_i held high 10 cycles during RELEASE (arst_o = 100) -> arst_o = 111 throughout; release starts 4 edges after the last high sample.
- arst_n_i low during STRETCH while sw_rst_i = 1 -> async reset wins; after release, full power-on timing; sw_rst_i is ignored until STRETCH.
- Parameter sweep SYNC_STAGES=3, N_OUT=1, STRETCH_CYCLES=1 -> arst_o[0] and done_o clear together at edge 5; no RELEASE state visited.
